// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//   VGA raster timing generator. A system-clock divider produces one pixel
//   step every CLK_DIV enabled clocks. Horizontal and vertical counters walk
//   the full raster, and every output is registered from those counters with
//   one clock of latency.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high reset
//   en           run enable; low freezes divider, counters and output stage
//   x_loc/y_loc  current pixel position (CW bits)
//   h_sync       horizontal sync, level HS_ACTIVE during the sync pulse
//   v_sync       vertical sync, level VS_ACTIVE during the sync pulse
//   video_on     high inside the visible H_DISPLAY x V_DISPLAY area
//   pixel_tick   one-clock pulse on the first clock a new position is shown
//   line_start   pixel_tick qualified with x_loc == 0
//   animate      pixel_tick qualified with (H_DISPLAY, V_DISPLAY-1)
//   frame_count  completed-frame counter, 8 bits, wraps 255 -> 0
//
// Optional feature
//   VGA_FRAME_CNT_EN : when defined, frame_count is a real counter. When
//   undefined, the port is tied to 8'd0 and no counter logic is built.
// ---------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int CLK_DIV   = 4,
  parameter int CW        = 10,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int HS_ACTIVE = 0,
  parameter int VS_ACTIVE = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  output logic [CW-1:0] x_loc,
  output logic [CW-1:0] y_loc,
  output logic          h_sync,
  output logic          v_sync,
  output logic          video_on,
  output logic          pixel_tick,
  output logic          line_start,
  output logic          animate,
  output logic [7:0]    frame_count
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  // A divide-by-one still needs a one-bit divider register.
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS    = CW'(H_DISPLAY);
  localparam logic [CW-1:0] V_VIS    = CW'(V_DISPLAY);
  localparam logic [CW-1:0] HS_START = CW'(H_DISPLAY + H_FRONT);
  localparam logic [CW-1:0] HS_END   = CW'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_DISPLAY + V_FRONT);
  localparam logic [CW-1:0] VS_END   = CW'(V_DISPLAY + V_FRONT + V_SYNC);
  localparam logic [CW-1:0] V_ANIM   = CW'(V_DISPLAY - 1);
  localparam logic          HS_ON    = 1'(HS_ACTIVE);
  localparam logic          VS_ON    = 1'(VS_ACTIVE);

  logic [DW-1:0] div;
  logic [CW-1:0] h;
  logic [CW-1:0] v;
  logic          tick;
  logic          tick_d;   // tick delayed to line up with the registered position
  logic          h_wrap;
  logic          v_wrap;

  // Half-open window test used by both sync decoders.
  function automatic logic in_window(input logic [CW-1:0] pos,
                                     input logic [CW-1:0] lo,
                                     input logic [CW-1:0] hi);
    return (pos >= lo) && (pos < hi);
  endfunction

  // Pixel step strobe and counter wrap conditions.
  always_comb begin
    tick   = en & (div == DIV_LAST);
    h_wrap = (h == H_LAST);
    v_wrap = (v == V_LAST);
  end

  // Divider and raster position counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      div    <= '0;
      h      <= '0;
      v      <= '0;
      tick_d <= 1'b0;
    end else if (en) begin
      div    <= (div == DIV_LAST) ? '0 : div + DW'(1);
      tick_d <= tick;
      if (tick) begin
        h <= h_wrap ? '0 : h + CW'(1);
        if (h_wrap) begin
          v <= v_wrap ? '0 : v + CW'(1);
        end
      end
    end
  end

  // Registered output stage; it freezes with en so strobes stay aligned
  // with the position they announce.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_loc      <= '0;
      y_loc      <= '0;
      h_sync     <= ~HS_ON;
      v_sync     <= ~VS_ON;
      video_on   <= 1'b0;
      pixel_tick <= 1'b0;
      line_start <= 1'b0;
      animate    <= 1'b0;
    end else if (en) begin
      x_loc      <= h;
      y_loc      <= v;
      h_sync     <= in_window(h, HS_START, HS_END) ? HS_ON : ~HS_ON;
      v_sync     <= in_window(v, VS_START, VS_END) ? VS_ON : ~VS_ON;
      video_on   <= (h < H_VIS) && (v < V_VIS);
      pixel_tick <= tick_d;
      line_start <= tick_d && (h == '0);
      animate    <= tick_d && (h == H_VIS) && (v == V_ANIM);
    end else begin
      pixel_tick <= 1'b0;
      line_start <= 1'b0;
      animate    <= 1'b0;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  logic [7:0] frame_cnt;

  // Frame counter steps on the tick that wraps the raster back to (0,0);
  // the output copy follows one enabled clock later, like x_loc/y_loc.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt   <= 8'd0;
      frame_count <= 8'd0;
    end else if (en) begin
      frame_count <= frame_cnt;
      if (tick && h_wrap && v_wrap) begin
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end
`else
  assign frame_count = 8'd0;
`endif

endmodule
